// File: rtl/calc_panel_pkg.sv
// Shared constants for the calculator front-panel I/O: seven-segment glyphs,
// fixed digit/decimal-point bits and the default debounce interval.
package calc_panel_pkg;

  // 20 ms at 12 MHz
  localparam int STABLE_CYCLES_DEFAULT = 240000;

  localparam logic SEG_DIG_ON = 1'b0;
  localparam logic SEG_DP_OFF = 1'b0;

  // Glyph bits are {g,f,e,d,c,b,a}, active-high for a common-cathode display.
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  function automatic logic [8:0] seg_pack(input logic [6:0] glyph);
    return {SEG_DIG_ON, SEG_DP_OFF, glyph};
  endfunction

endpackage

// File: rtl/calc_panel_io_seg7_decode.sv
// Nibble to 9-bit seven-segment pattern {digit enable, dp, g..a}; purely combinational.
module seg7_decode
  import calc_panel_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [8:0] pattern
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_HEX_0;
    case (nibble)
      4'h0: glyph = SEG_HEX_0;
      4'h1: glyph = SEG_HEX_1;
      4'h2: glyph = SEG_HEX_2;
      4'h3: glyph = SEG_HEX_3;
      4'h4: glyph = SEG_HEX_4;
      4'h5: glyph = SEG_HEX_5;
      4'h6: glyph = SEG_HEX_6;
      4'h7: glyph = SEG_HEX_7;
      4'h8: glyph = SEG_HEX_8;
      4'h9: glyph = SEG_HEX_9;
      4'hA: glyph = SEG_HEX_A;
      4'hB: glyph = SEG_HEX_B;
      4'hC: glyph = SEG_HEX_C;
      4'hD: glyph = SEG_HEX_D;
      4'hE: glyph = SEG_HEX_E;
      default: glyph = SEG_HEX_F;
    endcase
  end

  assign pattern = seg_pack(glyph);

endmodule

// File: rtl/calc_panel_io.sv
// Calculator front panel: per-button synchronizer + debounce, two hex digit decoders.
// Optional one-cycle press pulses on btn_press when PANEL_PRESS_PULSE_EN is defined.
module calc_panel_io
  import calc_panel_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int STABLE_CYCLES  = STABLE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
`ifdef PANEL_PRESS_PULSE_EN
  output logic [N_BTN-1:0] btn_press,
`endif
  input  logic [7:0]       value,
  output logic [8:0]       seg_led1,
  output logic [8:0]       seg_led2
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N_BTN-1:0] pressed;
  assign pressed = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic          s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips only after s2 has disagreed for STABLE_CYCLES consecutive edges.
    always_comb begin
      s1_d  = pressed[i];
      s2_d  = s1_q;
      lvl_d = lvl_q;
      cnt_d = '0;
      if (s2_q != lvl_q) begin
        if (cnt_q == CNT_MAX) begin
          lvl_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    assign btn_level[i] = lvl_q;
  end

`ifdef PANEL_PRESS_PULSE_EN
  logic [N_BTN-1:0] level_dly_q, level_dly_d, press_q, press_d;

  // Rising edge of the registered level, so the pulse lands one cycle after the rise.
  always_comb begin
    level_dly_d = btn_level;
    press_d     = btn_level & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_dly_q <= '0;
      press_q     <= '0;
    end else begin
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign btn_press = press_q;
`endif

  seg7_decode u_seg_lo (.nibble(value[3:0]), .pattern(seg_led1));
  seg7_decode u_seg_hi (.nibble(value[7:4]), .pattern(seg_led2));

endmodule

// File: tb/tb_calc_panel_io.sv
// Bench for calc_panel_io: directed debounce timing, segment sweep, and random
// button traffic checked against a sliding-window model of the debounce rule.
module tb_calc_panel_io;

  localparam int N      = 4;
  localparam int STABLE = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [7:0]   value;
  logic [8:0]   seg_led1;
  logic [8:0]   seg_led2;
`ifdef PANEL_PRESS_PULSE_EN
  logic [N-1:0] btn_press;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  calc_panel_io #(
    .N_BTN(N),
    .STABLE_CYCLES(STABLE),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
`ifdef PANEL_PRESS_PULSE_EN
    .btn_press(btn_press),
`endif
    .value(value),
    .seg_led1(seg_led1),
    .seg_led2(seg_led2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Segment glyph table straight from the display map.
  logic [8:0] seg_ref [16] = '{9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066, 9'h06D, 9'h07D, 9'h007,
                               9'h07F, 9'h06F, 9'h077, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h071};

  // Debounce model: a pressed sample takes two edges to reach the comparison
  // point; the level flips once the last STABLE comparison-point samples all
  // disagree with it.
  logic [N-1:0] m_s1, m_s2, m_level, m_prev_level, m_press;
  logic [N-1:0] m_win[$];

  initial begin
    m_s1 = '0; m_s2 = '0; m_level = '0; m_prev_level = '0; m_press = '0;
  end

  always @(posedge clk) begin
    logic [N-1:0] new_level;
    bit           all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_prev_level = '0; m_press = '0;
      m_win.delete();
    end else begin
      m_win.push_back(m_s2);
      if (m_win.size() > STABLE) void'(m_win.pop_front());
      new_level = m_level;
      for (int i = 0; i < N; i++) begin
        if (m_win.size() == STABLE) begin
          all_diff = 1'b1;
          foreach (m_win[j]) if (m_win[j][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) new_level[i] = ~m_level[i];
        end
      end
      m_press      = m_level & ~m_prev_level;
      m_prev_level = m_level;
      m_level      = new_level;
      m_s2         = m_s1;
      m_s1         = ~btn_raw;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_raw = 4'hF; value = 8'h00;
    step();
    n_checks++;
    if (btn_level !== 4'h0) begin
      n_fail++; $display("FAIL reset_level: got %h expected 0", btn_level);
    end
`ifdef PANEL_PRESS_PULSE_EN
    n_checks++;
    if (btn_press !== 4'h0) begin
      n_fail++; $display("FAIL reset_press: got %h expected 0", btn_press);
    end
`endif
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (btn_level !== 4'h0) begin
        n_fail++; $display("FAIL reset_hold cycle %0d: got %h expected 0", k, btn_level);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (btn_level !== {3'b000, (k >= 6)}) begin
        n_fail++; $display("FAIL press_level edge %0d: got %h expected %h", k, btn_level, {3'b000, (k >= 6)});
      end
`ifdef PANEL_PRESS_PULSE_EN
      n_checks++;
      if (btn_press !== {3'b000, (k == 7)}) begin
        n_fail++; $display("FAIL press_pulse edge %0d: got %h expected %h", k, btn_press, {3'b000, (k == 7)});
      end
`endif
    end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (btn_level[0] !== (k < 6)) begin
        n_fail++; $display("FAIL release_level edge %0d: got %b expected %b", k, btn_level[0], (k < 6));
      end
`ifdef PANEL_PRESS_PULSE_EN
      n_checks++;
      if (btn_press !== 4'h0) begin
        n_fail++; $display("FAIL release_no_pulse edge %0d: got %h expected 0", k, btn_press);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    btn_raw[1] = 1'b0;
    repeat (3) step();
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (btn_level[1] !== 1'b0) begin
        n_fail++; $display("FAIL glitch_ignored cycle %0d: got %b expected 0", k, btn_level[1]);
      end
    end
    btn_raw[1] = 1'b0;
    repeat (3) step();
    btn_raw[1] = 1'b1;
    step();
    btn_raw[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (btn_level[1] !== (k >= 6)) begin
        n_fail++; $display("FAIL bounce_then_hold edge %0d: got %b expected %b", k, btn_level[1], (k >= 6));
      end
    end
    btn_raw[1] = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_simultaneous();
    btn_raw[3:2] = 2'b00;
    repeat (8) step();
    n_checks++;
    if (btn_level !== 4'hC) begin
      n_fail++; $display("FAIL simul_press: got %h expected c", btn_level);
    end
    btn_raw[3:2] = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (btn_level[3:2] !== ((k >= 6) ? 2'b00 : 2'b11)) begin
        n_fail++; $display("FAIL simul_release edge %0d: got %b expected %b", k, btn_level[3:2], ((k >= 6) ? 2'b00 : 2'b11));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    btn_raw[0] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (btn_level[0] !== (k >= 6)) begin
        n_fail++; $display("FAIL reset_discards_count edge %0d: got %b expected %b", k, btn_level[0], (k >= 6));
      end
    end
    btn_raw[0] = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_seg_sweep();
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      #1;
      n_checks++;
      if (seg_led1 !== seg_ref[v % 16] || seg_led2 !== seg_ref[v / 16]) begin
        n_fail++;
        $display("FAIL seg_sweep value %h: got %h/%h expected %h/%h", value, seg_led1, seg_led2, seg_ref[v % 16], seg_ref[v / 16]);
      end
    end
    value = 8'h00; #1;
    n_checks++;
    if (seg_led1 !== 9'h03F || seg_led2 !== 9'h03F) begin
      n_fail++; $display("FAIL seg_spot_00: got %h/%h expected 03f/03f", seg_led1, seg_led2);
    end
    value = 8'h5A; #1;
    n_checks++;
    if (seg_led1 !== 9'h077 || seg_led2 !== 9'h06D) begin
      n_fail++; $display("FAIL seg_spot_5a: got %h/%h expected 077/06d", seg_led1, seg_led2);
    end
    @(negedge clk);
  endtask

  task automatic test_seg_independence();
    value = 8'hF3;
    for (int k = 0; k < 16; k++) begin
      rst     = (k % 5 == 2);
      btn_raw = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (seg_led1 !== 9'h04F || seg_led2 !== 9'h071) begin
        n_fail++; $display("FAIL seg_independent cycle %0d: got %h/%h expected 04f/071", k, seg_led1, seg_led2);
      end
      step();
    end
    rst = 1'b0; btn_raw = 4'hF;
    repeat (8) step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
      rst   = ($urandom_range(0, 99) == 0);
      value = 8'($urandom);
      step();
      n_checks++;
      if (btn_level !== m_level) begin
        n_fail++; $display("FAIL random_level cycle %0d: got %h expected %h", k, btn_level, m_level);
      end
`ifdef PANEL_PRESS_PULSE_EN
      n_checks++;
      if (btn_press !== m_press) begin
        n_fail++; $display("FAIL random_press cycle %0d: got %h expected %h", k, btn_press, m_press);
      end
`endif
      n_checks++;
      if (seg_led1 !== seg_ref[value[3:0]] || seg_led2 !== seg_ref[value[7:4]]) begin
        n_fail++; $display("FAIL random_seg value %h: got %h/%h", value, seg_led1, seg_led2);
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; btn_raw = 4'hF; value = 8'h00;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_seg_sweep();
    test_seg_independence();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_panel_io.md
Name: calc_panel_io

Overview:
- Front-panel I/O block for the simple calculator.
- Debounces N_BTN raw push-button inputs into clean active-high level signals.
- Decodes an 8-bit value into two 9-bit seven-segment patterns: low nibble on seg_led1, high nibble on seg_led2.
- Sits between the board pins and the calculator datapath/FSM.

Parameters:
- N_BTN, 4, number of button channels.
- STABLE_CYCLES, 240000, consecutive clk cycles a synchronized input must differ from the current level before the level flips (20 ms at 12 MHz); legal range ≥2.
- BTN_ACTIVE_LOW, 1, 1 = a raw pin reads 0 when pressed; 0 = a raw pin reads 1 when pressed.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button pins.
- btn_level  out  N_BTN  debounced level, 1 = pressed, registered.
- btn_press  out  N_BTN  one-cycle press pulse; present only with PANEL_PRESS_PULSE_EN.
- value  in  8  value to display.
- seg_led1  out  9  pattern for value[3:0], combinational.
- seg_led2  out  9  pattern for value[7:4], combinational.

Behaviour:
- Polarity: each raw bit is normalized to pressed = 1. It is inverted when BTN_ACTIVE_LOW = 1.
- Synchronizer: per channel, two flops after normalization. s2 is the second-stage output.
  - Reset value of both flops is 0 (released).
- Counter:
  - Per-channel counter, width $clog2(STABLE_CYCLES). Reset value 0.
  - When s2 == btn_level, the counter clears to 0.
  - When s2 != btn_level and counter < STABLE_CYCLES-1, the counter increments.
  - When s2 != btn_level and counter == STABLE_CYCLES-1, btn_level takes s2 and the counter clears.
- Latency: btn_level changes exactly STABLE_CYCLES edges after s2 first differs, provided s2 holds. This is 2+STABLE_CYCLES edges after the first edge that samples the new raw value.
- Glitches: a disagreement at s2 lasting fewer than STABLE_CYCLES cycles never changes btn_level, and the counter restarts from 0 afterwards.
- Channels are fully independent; simultaneous presses resolve independently.
- Reset:
  - btn_level = 0, counters = 0, synchronizers = 0, btn_press = 0.
  - A button held through reset release becomes a press after 2+STABLE_CYCLES cycles.
  - Reset asserted mid-count discards the count.
- Segment encoding:
  - Bit order: bit 8 = digit enable, active-low, always 0 (digit on); bit 7 = decimal point, always 0 (off); bits 6..0 = g,f,e,d,c,b,a, active-high (common cathode).
  - Nibble-to-pattern map (hex):
    - 0→03F, 1→006, 2→05B, 3→04F, 4→066, 5→06D, 6→07D, 7→007
    - 8→07F, 9→06F, A→077, b→07C, C→039, d→05E, E→079, F→071
  - Purely combinational: zero latency, unaffected by rst.

Optional Feature:
- Macro: PANEL_PRESS_PULSE_EN.
- When defined: port btn_press[N_BTN] exists and is registered. btn_press[i] = 1 for exactly one cycle, on the cycle after btn_level[i] rises 0→1. It does not pulse on release, and it is 0 during and immediately after reset.
- When undefined: the port and its logic are absent; the rest of the block is unchanged.

Decomposition:
- Package calc_panel_pkg holds:
  - the 16 SEG_HEX_* 7-bit glyph constants;
  - SEG_DIG_ON (1'b0) and SEG_DP_OFF (1'b0);
  - the default STABLE_CYCLES constant.
- One sub-module, seg7_decode (4-bit nibble in, 9-bit pattern out), instantiated twice.
- Debounce channels use a generate loop inside calc_panel_io.

Test Plan:
- Benches run with STABLE_CYCLES=4, N_BTN=4, BTN_ACTIVE_LOW=1.
- 1. Reset: assert rst 2 cycles with btn_raw=4'hF → btn_level=0 (and btn_press=0) on the first edge after rst; stays 0 for 20 cycles.
- 2. Clean press: btn_raw[0] 1→0 and held → btn_level[0] rises exactly 6 edges after the first sampling edge. With PANEL_PRESS_PULSE_EN, btn_press[0]=1 for one cycle, one cycle later.
- 3. Bounce: btn_raw[1] pulses low for 3 cycles, then stays high → btn_level[1] stays 0. Raw low for 3 cycles, high 1, then held low → level rises 6 edges after the final fall.
- 4. Release and simultaneous events: hold btn 2 and btn 3 pressed, release both on the same cycle → both levels fall on the same edge, 6 edges later. Assert rst mid-count → the count is discarded.
- 5. Segment sweep: value = 0x00..0xFF → seg_led1/seg_led2 match the map per nibble. Spot checks: value=0x00 → seg_led1=seg_led2=9'h03F; value=0x5A → seg_led1=9'h077, seg_led2=9'h06D.
- 6. Segment independence: toggle rst and btn_raw while value=0xF3 → seg_led1=9'h04F, seg_led2=9'h071, unchanged throughout.
